// File: rtl/id_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : id_stage_pipe
// Brief    : Decode stage with built-in ID/EXE pipeline register. Performs
//            register-file read with write-back bypass and condition gating.
//            Uses a valid/ready handshake towards IF and EXE, and supports
//            stall, flush and refresh of held operands.
// Options  : ID_PERF_CNT_EN adds the perf_stall / perf_flush counters.
// Revision : 1.0 - initial release
// ============================================================================
module id_stage_pipe #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int PC_W     = 32,
  localparam int REG_AW  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [PC_W-1:0]   pc_in,
  input  logic              hazard,
  input  logic              flush,
  input  logic [3:0]        sr,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  output logic [REG_AW-1:0] src1,
  output logic [REG_AW-1:0] src2,
  output logic              two_src,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              o_wb_en,
  output logic              o_mem_r,
  output logic              o_mem_w,
  output logic              o_s,
  output logic              o_b,
  output logic [3:0]        o_exe_cmd,
  output logic [DATA_W-1:0] o_val_rn,
  output logic [DATA_W-1:0] o_val_rm,
  output logic              o_imm,
  output logic [23:0]       o_imm24,
  output logic [11:0]       o_shift_op,
  output logic [REG_AW-1:0] o_dst,
  output logic [REG_AW-1:0] o_src1,
  output logic [REG_AW-1:0] o_src2,
  output logic              o_c,
`ifdef ID_PERF_CNT_EN
  output logic [31:0]       perf_stall,
  output logic [31:0]       perf_flush,
`endif
  output logic [PC_W-1:0]   o_pc
);

  // ALU command encodings
  localparam logic [3:0] c_CMD_MOV = 4'b0001;
  localparam logic [3:0] c_CMD_MVN = 4'b1001;
  localparam logic [3:0] c_CMD_ADD = 4'b0010;
  localparam logic [3:0] c_CMD_ADC = 4'b0011;
  localparam logic [3:0] c_CMD_SUB = 4'b0100;
  localparam logic [3:0] c_CMD_SBC = 4'b0101;
  localparam logic [3:0] c_CMD_AND = 4'b0110;
  localparam logic [3:0] c_CMD_ORR = 4'b0111;
  localparam logic [3:0] c_CMD_EOR = 4'b1000;

  // Instruction fields
  logic [3:0] w_cond;
  logic [1:0] w_mode;
  logic [3:0] w_opcode;
  logic       w_s_bit;
  logic       w_store;
  logic       w_load;

  assign w_cond   = instr[31:28];
  assign w_mode   = instr[27:26];
  assign w_opcode = instr[24:21];
  assign w_s_bit  = instr[20];
  assign w_store  = (w_mode == 2'b01) & ~w_s_bit;

  // Register sources: a store reads Rd as its second operand (the data to write)
  assign src1    = instr[16 +: REG_AW];
  assign src2    = w_store ? instr[12 +: REG_AW] : instr[0 +: REG_AW];
  assign two_src = w_store | ~instr[25];

  // Control unit decode
  logic [3:0] w_cmd;
  logic       w_wb, w_mr, w_mw, w_s, w_b;

  // Decode mode/opcode into ALU command and control flags
  always_comb begin
    w_cmd = 4'b0000;
    w_wb  = 1'b0;
    w_mr  = 1'b0;
    w_mw  = 1'b0;
    w_s   = 1'b0;
    w_b   = 1'b0;
    case (w_mode)
      2'b00: begin
        w_s = w_s_bit;
        case (w_opcode)
          4'b1101: begin w_cmd = c_CMD_MOV; w_wb = 1'b1; end
          4'b1111: begin w_cmd = c_CMD_MVN; w_wb = 1'b1; end
          4'b0100: begin w_cmd = c_CMD_ADD; w_wb = 1'b1; end
          4'b0101: begin w_cmd = c_CMD_ADC; w_wb = 1'b1; end
          4'b0010: begin w_cmd = c_CMD_SUB; w_wb = 1'b1; end
          4'b0110: begin w_cmd = c_CMD_SBC; w_wb = 1'b1; end
          4'b0000: begin w_cmd = c_CMD_AND; w_wb = 1'b1; end
          4'b1100: begin w_cmd = c_CMD_ORR; w_wb = 1'b1; end
          4'b0001: begin w_cmd = c_CMD_EOR; w_wb = 1'b1; end
          4'b1010: w_cmd = c_CMD_SUB;   // CMP: flags only
          4'b1000: w_cmd = c_CMD_AND;   // TST: flags only
          default: ;
        endcase
      end
      2'b01: begin
        if (w_opcode == 4'b0100) begin
          w_cmd = c_CMD_ADD;
          if (w_s_bit) begin
            w_mr = 1'b1;
            w_wb = 1'b1;
          end else begin
            w_mw = 1'b1;
          end
        end
      end
      2'b10:   w_b = 1'b1;
      default: ;
    endcase
  end

  // Condition check against {N,Z,C,V}
  logic w_n, w_z, w_c, w_v, w_cond_ok;
  assign {w_n, w_z, w_c, w_v} = sr;

  // Evaluate the condition field
  always_comb begin
    w_cond_ok = 1'b1;
    case (w_cond)
      4'b0000: w_cond_ok = w_z;
      4'b0001: w_cond_ok = ~w_z;
      4'b0010: w_cond_ok = w_c;
      4'b0011: w_cond_ok = ~w_c;
      4'b0100: w_cond_ok = w_n;
      4'b0101: w_cond_ok = ~w_n;
      4'b0110: w_cond_ok = w_v;
      4'b0111: w_cond_ok = ~w_v;
      4'b1000: w_cond_ok = w_c & ~w_z;
      4'b1001: w_cond_ok = ~w_c | w_z;
      4'b1010: w_cond_ok = (w_n == w_v);
      4'b1011: w_cond_ok = (w_n != w_v);
      4'b1100: w_cond_ok = ~w_z & (w_n == w_v);
      4'b1101: w_cond_ok = w_z | (w_n != w_v);
      default: w_cond_ok = 1'b1;
    endcase
  end

  // Register file with write-back bypass on read
  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [DATA_W-1:0] w_rn_val, w_rm_val;

  assign w_rn_val = (wb_en && (wb_dest == src1)) ? wb_data : r_regs[src1];
  assign w_rm_val = (wb_en && (wb_dest == src2)) ? wb_data : r_regs[src2];

  // Register-file write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (wb_en) begin
      r_regs[wb_dest] <= wb_data;
    end
  end

  // Handshake
  assign in_ready = (~out_valid | out_ready) & ~hazard & ~flush;
  assign w_load   = in_valid & in_ready;

  // ID/EXE pipeline register: flush > load > drain bubble > hold (with operand refresh)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      o_wb_en    <= 1'b0;
      o_mem_r    <= 1'b0;
      o_mem_w    <= 1'b0;
      o_s        <= 1'b0;
      o_b        <= 1'b0;
      o_exe_cmd  <= '0;
      o_val_rn   <= '0;
      o_val_rm   <= '0;
      o_imm      <= 1'b0;
      o_imm24    <= '0;
      o_shift_op <= '0;
      o_dst      <= '0;
      o_src1     <= '0;
      o_src2     <= '0;
      o_c        <= 1'b0;
      o_pc       <= '0;
    end else if (flush || (!w_load && out_valid && out_ready)) begin
      out_valid <= 1'b0;
      o_wb_en   <= 1'b0;
      o_mem_r   <= 1'b0;
      o_mem_w   <= 1'b0;
      o_s       <= 1'b0;
      o_b       <= 1'b0;
      o_exe_cmd <= '0;
    end else if (w_load) begin
      out_valid  <= 1'b1;
      o_wb_en    <= w_wb & w_cond_ok;
      o_mem_r    <= w_mr & w_cond_ok;
      o_mem_w    <= w_mw & w_cond_ok;
      o_s        <= w_s  & w_cond_ok;
      o_b        <= w_b  & w_cond_ok;
      o_exe_cmd  <= w_cmd;
      o_val_rn   <= w_rn_val;
      o_val_rm   <= w_rm_val;
      o_imm      <= instr[25];
      o_imm24    <= instr[23:0];
      o_shift_op <= instr[11:0];
      o_dst      <= instr[12 +: REG_AW];
      o_src1     <= src1;
      o_src2     <= src2;
      o_c        <= sr[1];
      o_pc       <= pc_in;
    end else if (out_valid && wb_en) begin
      // Held instruction: track write-backs so operands never go stale
      if (wb_dest == o_src1) o_val_rn <= wb_data;
      if (wb_dest == o_src2) o_val_rm <= wb_data;
    end
  end

`ifdef ID_PERF_CNT_EN
  // Saturating stall and flush cycle counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall <= '0;
      perf_flush <= '0;
    end else begin
      if (in_valid && !in_ready && (perf_stall != 32'hFFFF_FFFF))
        perf_stall <= perf_stall + 32'd1;
      if (flush && (perf_flush != 32'hFFFF_FFFF))
        perf_flush <= perf_flush + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire
